raster_line_draw: RTL and testbench
===================================

Name: raster_line_draw

Overview:
- Runtime-programmable, arbitrary-slope line primitive for the frame/score overlay; successor to the fixed-slope diagonal drawers.
- Latches endpoints once per frame and computes a fixed-point x-step with a serial divider during vertical blanking.
- Walks the line one scanline at a time, asserting `draw` for each covered pixel with configurable thickness.
- Feeds the colour mux alongside the static frame and score primitives.

Parameters:
- H_ACTIVE, 640: active pixels per line; last active x is H_ACTIVE-1.
- V_ACTIVE, 480: active lines per frame.
- COORD_W, 16: width of pixel coordinates and endpoints.
- FRAC_W, 16: fractional bits of step and accumulator.
- THICK, 2: horizontal thickness in pixels, >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  pixel strobe (VGA ready); qualifies pixel_x/pixel_y
- pixel_x  in  COORD_W  current raster x
- pixel_y  in  COORD_W  current raster y
- line_en  in  1  line visible when 1; sampled at frame latch
- x0, y0, x1, y1  in  COORD_W each  line endpoints, any order
- busy  out  1  latch/normalise/divide in progress
- draw  out  1  current pixel lies on the line

Behaviour:
- Reset (rst=0, async): state IDLE, valid=0, acc=0, step=0, busy=0, draw=0.
- Frame latch: en && pixel_x==H_ACTIVE-1 && pixel_y==V_ACTIVE-1.
  - Capture x0,y0,x1,y1,line_en; clear acc; go LATCH.
  - Endpoint changes at any other time are ignored until the next latch.
- States, all advancing on clk, not gated by en:
  - IDLE.
  - LATCH (1 cycle): normalise so ya<=yb, swapping endpoint pairs if y0>y1. Compute adx=|xb-xa|, ady=yb-ya, dir=(xb>=xa).
  - DIV, or skip to READY if ady==0: restoring divide step=floor((adx<<FRAC_W)/ady). Exactly COORD_W+FRAC_W cycles.
  - READY: valid=line_en. Remain here until the next frame latch.
- busy=1 in LATCH and DIV.
- valid=0 from LATCH until READY. While valid=0, draw=0.
- Horizontal case (ady==0): step=(adx+1)<<FRAC_W.
- Vertical case (adx==0): step=0.
- Row walk:
  - On en && pixel_x==H_ACTIVE-1 && ya<=pixel_y<=yb: acc<=acc+step.
  - acc is COORD_W+FRAC_W+1 bits and cannot overflow for coordinates <H_ACTIVE.
- Per-row span offsets:
  - off_lo=acc>>FRAC_W.
  - off_hi=max(off_lo, ((acc+step)>>FRAC_W)-1).
  - If pixel_y==yb, off_hi=adx.
  - Then clamp both offsets to <=adx.
- draw=1 iff all of: valid, ya<=pixel_y<=yb, pixel_x in span.
  - dir=1 span: [xa+off_lo, xa+off_hi+THICK-1].
  - dir=0 span: [xa-off_hi-THICK+1, xa-off_lo].
  - Arithmetic is signed COORD_W+1. A negative lower bound clips to 0; an upper bound >=H_ACTIVE clips to H_ACTIVE-1.
- draw is combinational from pixel_x/pixel_y and registered state: zero latency, same timing as the static frame primitives.
- Simultaneous frame latch and row-walk update: the latch wins (acc cleared). The row walk cannot fire then anyway, since pixel_y==V_ACTIVE-1 only if yb==V_ACTIVE-1, and the latch has priority.
- Frame latch while busy (DIV unfinished): restart LATCH with the new endpoints.
- Reset mid-DIV: back to IDLE. draw=0 until the next latch completes.

Test Plan:
- Latch (63,47)-(255,191), line_en=1. After latch, busy lasts 1+32 clk; then step=87381.
  - Row 47 draws x63..64.
  - Row 48 draws x64..65.
  - Row 191 ends at x256.
  - Rows 46 and 192 draw nothing.
- Right-to-left (255,288)-(63,432):
  - Row 288 draws x254..255.
  - Row 432 span ends at x62.
  - Result is the mirror of the first scenario.
- Special cases:
  - Swapped endpoints (255,191)-(63,47): draw map identical to the first scenario, checked pixel-by-pixel over a full frame.
  - Horizontal (10,100)-(20,100): DIV skipped, busy 1 cycle; only row 100 draws, x10..21.
  - Vertical (320,0)-(320,479): every row draws x320..321; step=0.
- Robustness:
  - Change x1 mid-frame: current frame unchanged; new line appears after the next latch.
  - line_en=0: draw=0 all frame.
  - Assert rst low during DIV: busy=0 and draw=0 immediately, and stay 0 until the next latch completes.

Source files
------------

// File: rtl/raster_line_draw.sv
// rtl/raster_line_draw.sv - arbitrary-slope line overlay primitive
// Endpoints are latched once per frame; the x-step is produced by a serial divider during blanking.
module raster_line_draw #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 16,
  parameter int FRAC_W   = 16,
  parameter int THICK    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               line_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               draw
);

  localparam int DIV_W = COORD_W + FRAC_W;
  localparam int ACC_W = DIV_W + 1;
  localparam int CNT_W = $clog2(DIV_W);
  localparam int OFF_W = COORD_W + 2;
  localparam int S_W   = COORD_W + 1;
  localparam logic signed [S_W-1:0] TK_M1  = S_W'(THICK - 1);
  localparam logic signed [S_W-1:0] LAST_X = S_W'(H_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DIV, S_READY} state_t;
  state_t r_state, w_next;

  logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
  logic               r_line_en;
  logic [COORD_W-1:0] r_xa, r_ya, r_yb, r_adx, r_ady;
  logic               r_dir;
  logic [DIV_W-1:0]   r_step;
  logic [ACC_W-1:0]   r_acc;
  logic               r_valid;
  logic [DIV_W-1:0]   r_dvd;
  logic [COORD_W-1:0] r_rem;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_frame, w_walk, w_last, w_in_rows;
  logic               w_swap, w_dir;
  logic [COORD_W-1:0] w_xa, w_xb, w_ya, w_yb, w_adx, w_ady;
  logic [COORD_W:0]   w_rem_sh;
  logic               w_ge;
  logic [COORD_W-1:0] w_rem_nx;
  logic [DIV_W-1:0]   w_quo;

  assign w_frame   = en && (pixel_x == COORD_W'(H_ACTIVE - 1)) && (pixel_y == COORD_W'(V_ACTIVE - 1));
  assign w_in_rows = (pixel_y >= r_ya) && (pixel_y <= r_yb);
  assign w_walk    = en && (pixel_x == COORD_W'(H_ACTIVE - 1)) && w_in_rows;
  assign w_last    = (r_cnt == CNT_W'(DIV_W - 1));

  // Normalisation from the raw latched endpoints so that ya <= yb.
  assign w_swap = r_y0 > r_y1;
  assign w_xa   = w_swap ? r_x1 : r_x0;
  assign w_xb   = w_swap ? r_x0 : r_x1;
  assign w_ya   = w_swap ? r_y1 : r_y0;
  assign w_yb   = w_swap ? r_y0 : r_y1;
  assign w_dir  = w_xb >= w_xa;
  assign w_adx  = w_dir ? (w_xb - w_xa) : (w_xa - w_xb);
  assign w_ady  = w_yb - w_ya;

  // One restoring-division step per cycle; quotient bits shift in behind the dividend.
  assign w_rem_sh = {r_rem, r_dvd[DIV_W-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_ady};
  assign w_rem_nx = w_ge ? COORD_W'(w_rem_sh - {1'b0, r_ady}) : w_rem_sh[COORD_W-1:0];
  assign w_quo    = {r_dvd[DIV_W-2:0], w_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LATCH: w_next = (w_ady == '0) ? S_READY : S_DIV;
      S_DIV:   if (w_last) w_next = S_READY;
      default: ;
    endcase
    if (w_frame) w_next = S_LATCH;
  end

  assign busy = (r_state == S_LATCH) || (r_state == S_DIV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0;
      r_line_en <= 1'b0;
      r_xa <= '0; r_ya <= '0; r_yb <= '0; r_adx <= '0; r_ady <= '0;
      r_dir <= 1'b0;
      r_step <= '0;
      r_acc <= '0;
      r_valid <= 1'b0;
      r_dvd <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_frame) begin
      r_x0 <= x0; r_y0 <= y0; r_x1 <= x1; r_y1 <= y1;
      r_line_en <= line_en;
      r_acc <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LATCH: begin
          r_xa <= w_xa; r_ya <= w_ya; r_yb <= w_yb;
          r_adx <= w_adx; r_ady <= w_ady; r_dir <= w_dir;
          r_dvd <= {w_adx, {FRAC_W{1'b0}}};
          r_rem <= '0;
          r_cnt <= '0;
          if (w_ady == '0) begin
            r_step <= {w_adx + 1'b1, {FRAC_W{1'b0}}};
            r_valid <= r_line_en;
          end
        end
        S_DIV: begin
          r_dvd <= w_quo;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_step <= w_quo;
            r_valid <= r_line_en;
          end
        end
        S_READY: if (w_walk) r_acc <= r_acc + ACC_W'(r_step);
        default: ;
      endcase
    end
  end

  logic [COORD_W:0]        w_off_lo;
  logic [OFF_W-1:0]        w_hi_sum, w_off_hi;
  logic [COORD_W-1:0]      w_lo_c, w_hi_c;
  logic signed [S_W-1:0]   w_xa_s, w_lo_s, w_hi_s, w_px_s;
  logic signed [S_W-1:0]   w_lo, w_hi, w_lo_clip, w_hi_clip;

  // off_hi is one less than the next row's starting offset, but never below this row's start.
  assign w_off_lo = r_acc[ACC_W-1:FRAC_W];
  assign w_hi_sum = OFF_W'(({1'b0, r_acc} + (ACC_W + 1)'(r_step)) >> FRAC_W);

  always_comb begin
    w_off_hi = (w_hi_sum > (OFF_W'(w_off_lo) + 1'b1)) ? (w_hi_sum - 1'b1) : OFF_W'(w_off_lo);
    if (pixel_y == r_yb) w_off_hi = OFF_W'(r_adx);
  end

  assign w_lo_c = (OFF_W'(w_off_lo) > OFF_W'(r_adx)) ? r_adx : w_off_lo[COORD_W-1:0];
  assign w_hi_c = (w_off_hi > OFF_W'(r_adx)) ? r_adx : w_off_hi[COORD_W-1:0];

  assign w_xa_s = $signed({1'b0, r_xa});
  assign w_lo_s = $signed({1'b0, w_lo_c});
  assign w_hi_s = $signed({1'b0, w_hi_c});
  assign w_px_s = $signed({1'b0, pixel_x});

  assign w_lo = r_dir ? (w_xa_s + w_lo_s) : (w_xa_s - w_hi_s - TK_M1);
  assign w_hi = r_dir ? (w_xa_s + w_hi_s + TK_M1) : (w_xa_s - w_lo_s);

  assign w_lo_clip = (w_lo < 0) ? '0 : w_lo;
  assign w_hi_clip = (w_hi > LAST_X) ? LAST_X : w_hi;

  assign draw = r_valid && w_in_rows && (w_px_s >= w_lo_clip) && (w_px_s <= w_hi_clip);

endmodule

// File: tb/tb_raster_line_draw.sv
// tb/tb_raster_line_draw.sv - self-checking bench for raster_line_draw
// Frames are walked row by row; each checked row is swept pixel by pixel against a closed-form line model.
module tb_raster_line_draw;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int CW = 16;
  localparam int FW = 16;
  localparam int TK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          line_en = 1'b0;
  logic [CW-1:0] pixel_x = '0, pixel_y = '0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic          busy, draw;

  raster_line_draw #(.H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .FRAC_W(FW), .THICK(TK)) dut (
    .clk(clk), .rst(rst), .en(en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_en(line_en), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .draw(draw)
  );

  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_x0, m_y0, m_x1, m_y1;
  bit m_len = 0;
  bit m_valid = 0;

  typedef struct {int y; int lo; int hi;} span_t;
  span_t dq[$];
  int mid_row = -1;
  int mid_x1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel from the line definition: acc on row y is (y-ya)*step in closed form.
  function automatic logic model_draw(input int x, input int y);
    int xa, ya, xb, yb, adx, ady;
    bit dir;
    longint step, acc, off_lo, off_hi, lo, hi;
    if (!m_valid || !m_len) return 1'b0;
    if (m_y0 > m_y1) begin xa = m_x1; ya = m_y1; xb = m_x0; yb = m_y0; end
    else             begin xa = m_x0; ya = m_y0; xb = m_x1; yb = m_y1; end
    if (y < ya || y > yb) return 1'b0;
    dir = (xb >= xa);
    adx = dir ? xb - xa : xa - xb;
    ady = yb - ya;
    step = (ady == 0) ? (longint'(adx + 1) << FW) : ((longint'(adx) << FW) / ady);
    acc = longint'(y - ya) * step;
    off_lo = acc >> FW;
    off_hi = ((acc + step) >> FW) - 1;
    if (off_hi < off_lo) off_hi = off_lo;
    if (y == yb) off_hi = adx;
    if (off_lo > adx) off_lo = adx;
    if (off_hi > adx) off_hi = adx;
    if (dir) begin lo = xa + off_lo; hi = xa + off_hi + TK - 1; end
    else     begin lo = xa - off_hi - TK + 1; hi = xa - off_lo; end
    if (lo < 0) lo = 0;
    if (hi > H - 1) hi = H - 1;
    return (x >= lo && x <= hi);
  endfunction

  function automatic bit near_ends(input int y);
    int ya, yb;
    ya = (m_y0 < m_y1) ? m_y0 : m_y1;
    yb = (m_y0 < m_y1) ? m_y1 : m_y0;
    return (y >= ya - 1 && y <= ya + 1) || (y >= yb - 1 && y <= yb + 1);
  endfunction

  function automatic bit in_dq(input int y);
    foreach (dq[i]) if (dq[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_line(input int ax0, input int ay0, input int ax1, input int ay1, input bit len);
    x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1); line_en = len;
  endtask

  task automatic latch_model();
    m_x0 = int'(x0); m_y0 = int'(y0); m_x1 = int'(x1); m_y1 = int'(y1);
    m_len = line_en; m_valid = 0;
  endtask

  task automatic add_span(input int y, input int lo, input int hi);
    span_t s;
    s.y = y; s.lo = lo; s.hi = hi;
    dq.push_back(s);
  endtask

  task automatic check_row(input int y);
    logic [H-1:0] obs, exp, mask;
    for (int x = 0; x < H; x++) begin
      pixel_x = 16'(x);
      #2;
      obs[x] = draw;
      exp[x] = model_draw(x, y);
    end
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL row%0d observed=%h expected=%h", y, obs, exp);
    end
    foreach (dq[i]) begin
      if (dq[i].y == y) begin
        mask = '0;
        for (int x = dq[i].lo; x <= dq[i].hi; x++) mask[x] = 1'b1;
        n_vec++;
        assert (obs === mask) else begin
          n_err++;
          $error("FAIL span%0d observed=%h expected=%h", y, obs, mask);
        end
      end
    end
  endtask

  task automatic end_of_row(input int y);
    pixel_x = 16'(H - 1);
    pixel_y = 16'(y);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    if (y == V - 1) latch_model();
  endtask

  task automatic run_frame(input bit full);
    for (int y = 0; y < V; y++) begin
      pixel_y = 16'(y);
      if (y == mid_row) x1 = 16'(mid_x1);
      if (full || near_ends(y) || in_dq(y) || $urandom_range(39) == 0) check_row(y);
      end_of_row(y);
    end
    mid_row = -1;
    dq.delete();
  endtask

  task automatic wait_ready(input string tag);
    int cnt, expc;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    expc = (m_y0 == m_y1) ? 1 : CW + FW + 1;
    chk(tag, cnt, expc);
    m_valid = 1;
  endtask

  task automatic add_a_spans();
    add_span(46, 1, 0); add_span(47, 63, 64); add_span(48, 64, 65);
    add_span(191, 254, 256); add_span(192, 1, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_line(63, 47, 255, 191, 1);
    pixel_x = 16'd63; pixel_y = 16'd47;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_draw", {31'b0, draw}, 0);
    rst = 1'b1;
    latch_model();
    @(posedge clk);
    #1;
    chk("idle_draw", {31'b0, draw}, 0);
    run_frame(0);
    wait_ready("busy_a");

    add_a_spans();
    set_line(255, 288, 63, 432, 1);
    run_frame(0);
    wait_ready("busy_rtl");

    add_span(287, 1, 0); add_span(288, 254, 255); add_span(432, 62, 64); add_span(433, 1, 0);
    set_line(255, 191, 63, 47, 1);
    run_frame(0);
    wait_ready("busy_swap");

    add_a_spans();
    set_line(10, 100, 20, 100, 1);
    run_frame(1);
    wait_ready("busy_horiz");

    add_span(99, 1, 0); add_span(100, 10, 21); add_span(101, 1, 0);
    set_line(320, 0, 320, 479, 1);
    run_frame(0);
    wait_ready("busy_vert");

    add_span(0, 320, 321); add_span(240, 320, 321); add_span(479, 320, 321);
    set_line(63, 47, 255, 191, 1);
    run_frame(0);
    wait_ready("busy_a2");

    add_a_spans();
    mid_row = 100; mid_x1 = 400;
    run_frame(0);
    wait_ready("busy_moved");

    add_span(47, 63, 65); add_span(48, 65, 67); add_span(191, 399, 401);
    set_line(100, 200, 300, 260, 0);
    run_frame(0);
    wait_ready("busy_off");

    add_span(200, 1, 0); add_span(230, 1, 0); add_span(260, 1, 0);
    set_line(63, 47, 255, 191, 1);
    run_frame(0);

    repeat (10) @(posedge clk);
    #1;
    chk("div_busy", {31'b0, busy}, 1);
    pixel_x = 16'd63; pixel_y = 16'd47;
    rst = 1'b0;
    #1;
    chk("rst_div_busy", {31'b0, busy}, 0);
    chk("rst_div_draw", {31'b0, draw}, 0);
    m_valid = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_draw", {31'b0, draw}, 0);
    run_frame(0);

    repeat (5) @(posedge clk);
    #1;
    set_line($urandom_range(H - 1), $urandom_range(V - 1), $urandom_range(H - 1), $urandom_range(V - 1), 1);
    pixel_x = 16'(H - 1); pixel_y = 16'(V - 1); en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    latch_model();
    wait_ready("busy_restart");

    for (int i = 0; i < 5; i++) begin
      set_line($urandom_range(H - 1), $urandom_range(V - 1), $urandom_range(H - 1), $urandom_range(V - 1), 1);
      run_frame(0);
      wait_ready($sformatf("busy_rand%0d", i));
    end
    run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
